// File: rtl/mem_request_queue_pkg.sv
// rtl/mem_request_queue_pkg.sv - shared types and sizing constants for the memory request queue
package mem_request_queue_pkg;

  localparam int MRQ_ADDRESS_WIDTH = 32;
  localparam int MRQ_QUEUE_DEPTH   = 16;
  localparam int MRQ_AGE_WIDTH     = 16;

  // Operation classes produced by the trace parser
  typedef enum logic [1:0] {
    OP_NONE     = 2'd0,
    DATA_READ   = 2'd1,
    DATA_WRITE  = 2'd2,
    INSTR_FETCH = 2'd3
  } parsed_op_t;

  typedef struct packed {
    parsed_op_t                   opcode;
    logic [MRQ_ADDRESS_WIDTH-1:0] address;
  } mem_req_t;

endpackage

// File: rtl/mem_request_queue_if.sv
// rtl/mem_request_queue_if.sv - parser/scheduler side signals of the memory request queue
interface mem_request_queue_if
  import mem_request_queue_pkg::*;
#(
  parameter int ADDRESS_WIDTH = MRQ_ADDRESS_WIDTH,
  parameter int QUEUE_DEPTH   = MRQ_QUEUE_DEPTH,
  parameter int AGE_WIDTH     = MRQ_AGE_WIDTH
);

  localparam int OCC_W = $clog2(QUEUE_DEPTH) + 1;

  logic                     op_ready_s;
  parsed_op_t               opcode;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     pop;
  logic                     queue_full;
  logic                     queue_empty;
  logic [OCC_W-1:0]         occupancy;
  logic                     head_valid;
  parsed_op_t               head_opcode;
  logic [ADDRESS_WIDTH-1:0] head_address;
  logic [AGE_WIDTH-1:0]     head_age;
  logic                     overflow;

  // Parser and scheduler together drive the requests and consume the head
  modport master (
    output op_ready_s, opcode, address, pop,
    input  queue_full, queue_empty, occupancy, head_valid,
           head_opcode, head_address, head_age, overflow
  );

  // The queue itself
  modport slave (
    input  op_ready_s, opcode, address, pop,
    output queue_full, queue_empty, occupancy, head_valid,
           head_opcode, head_address, head_age, overflow
  );

endinterface

// File: rtl/mem_request_queue_sat_age_counter.sv
// rtl/mem_request_queue_sat_age_counter.sv - per-entry age counter that saturates at all-ones
module sat_age_counter #(
  parameter int AGE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  output logic [AGE_WIDTH-1:0] age
);

  // Clear wins over counting so a slot reused in the same cycle it is freed starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (clear) begin
      age <= '0;
    end else if (enable && (age != {AGE_WIDTH{1'b1}})) begin
      age <= age + AGE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_request_queue.sv
// rtl/mem_request_queue.sv - circular request buffer between trace parser and DRAM scheduler
module mem_request_queue
  import mem_request_queue_pkg::*;
#(
  parameter int ADDRESS_WIDTH = MRQ_ADDRESS_WIDTH,
  parameter int QUEUE_DEPTH   = MRQ_QUEUE_DEPTH,
  parameter int AGE_WIDTH     = MRQ_AGE_WIDTH
) (
  input logic               clk,
  input logic               rst,
  mem_request_queue_if.slave q
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [OCC_W-1:0]         occ;
  logic                     ovf;
  logic [QUEUE_DEPTH-1:0]   valid;
  parsed_op_t               op_mem   [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem [QUEUE_DEPTH];
  logic [AGE_WIDTH-1:0]     age      [QUEUE_DEPTH];

  logic full;
  logic empty;
  logic do_push;
  logic do_pop;
  logic do_drop;

  assign full    = (occ == OCC_W'(QUEUE_DEPTH));
  assign empty   = (occ == '0);
  // A pop on a full queue frees the slot the incoming request needs
  assign do_push = q.op_ready_s && (!full || q.pop);
  assign do_pop  = q.pop && !empty;
  assign do_drop = q.op_ready_s && full && !q.pop;

  // Pointer, occupancy and sticky overflow bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop) begin
        occ <= occ + OCC_W'(1);
      end else if (do_pop && !do_push) begin
        occ <= occ - OCC_W'(1);
      end
      if (do_drop) ovf <= 1'b1;
    end
  end

  // Entry valid bits; a push into the slot being popped leaves it valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (do_push && (wr_ptr == PTR_W'(i))) begin
          valid[i] <= 1'b1;
        end else if (do_pop && (rd_ptr == PTR_W'(i))) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  // Payload storage; contents are never read while the slot is invalid, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      op_mem[wr_ptr]   <= q.opcode;
      addr_mem[wr_ptr] <= q.address;
    end
  end

  genvar g;
  generate
    for (g = 0; g < QUEUE_DEPTH; g++) begin : g_age
      sat_age_counter #(
        .AGE_WIDTH (AGE_WIDTH)
      ) u_age (
        .clk    (clk),
        .rst    (rst),
        .clear  (do_push && (wr_ptr == PTR_W'(g))),
        .enable (valid[g]),
        .age    (age[g])
      );
    end
  endgenerate

  assign q.queue_full  = full;
  assign q.queue_empty = empty;
  assign q.occupancy   = occ;
  assign q.head_valid  = !empty;
  assign q.overflow    = ovf;

  // Head mux presents the oldest entry, forced to zero when nothing is queued
  always_comb begin
    q.head_opcode  = OP_NONE;
    q.head_address = '0;
    q.head_age     = '0;
    if (!empty) begin
      q.head_opcode  = op_mem[rd_ptr];
      q.head_address = addr_mem[rd_ptr];
      q.head_age     = age[rd_ptr];
    end
  end

endmodule
